// File: rtl/msrv32_trap_ctrl.sv
// rtl/msrv32_trap_ctrl.sv - machine-mode trap controller for the msrv32 core
// Prioritises interrupts and exceptions, sequences trap entry and MRET return.
module msrv32_trap_ctrl (
   input  logic       clk_in,
   input  logic       reset_in,
   input  logic       illegal_instr_in,
   input  logic       misaligned_load_in,
   input  logic       misaligned_store_in,
   input  logic       misaligned_instr_in,
   input  logic       ecall_in,
   input  logic       ebreak_in,
   input  logic       mret_in,
   input  logic       mie_in,
   input  logic       meie_in,
   input  logic       mtie_in,
   input  logic       msie_in,
   input  logic       meip_in,
   input  logic       mtip_in,
   input  logic       msip_in,
   output logic       trap_taken_out,
   output logic [1:0] pc_src_out,
   output logic       flush_out,
   output logic       set_cause_out,
   output logic [3:0] cause_out,
   output logic       i_or_e_out,
   output logic       set_epc_out,
   output logic       instret_inc_out,
   output logic       mie_clear_out,
   output logic       mie_set_out
);

   typedef enum logic [1:0] {
      ST_RESET       = 2'b00,
      ST_OPERATING   = 2'b01,
      ST_TRAP_TAKEN  = 2'b10,
      ST_TRAP_RETURN = 2'b11
   } state_e;

   localparam logic [1:0] PC_BOOT = 2'b00;
   localparam logic [1:0] PC_EPC  = 2'b01;
   localparam logic [1:0] PC_TRAP = 2'b10;
   localparam logic [1:0] PC_NEXT = 2'b11;

   state_e     state_q, state_d;
   logic [3:0] cause_q, cause_d;
   logic       i_or_e_q, i_or_e_d;

   logic       operating;
   logic       irq_mei, irq_msi, irq_mti;
   logic       irq, exc;
   logic [3:0] irq_cause, exc_cause;

   assign operating = (state_q == ST_OPERATING);

   // Requests only count while operating; the flushed slot during trap/return is discarded.
   assign irq_mei = mie_in & meie_in & meip_in;
   assign irq_msi = mie_in & msie_in & msip_in;
   assign irq_mti = mie_in & mtie_in & mtip_in;
   assign irq     = operating & (irq_mei | irq_msi | irq_mti);
   assign exc     = operating & (illegal_instr_in | misaligned_load_in | misaligned_store_in |
                                 misaligned_instr_in | ecall_in | ebreak_in);

   always_comb begin
      irq_cause = 4'd7;
      if (irq_mei) begin
         irq_cause = 4'd11;
      end else if (irq_msi) begin
         irq_cause = 4'd3;
      end
   end

   always_comb begin
      exc_cause = 4'd4;
      if (misaligned_instr_in) begin
         exc_cause = 4'd0;
      end else if (illegal_instr_in) begin
         exc_cause = 4'd2;
      end else if (ebreak_in) begin
         exc_cause = 4'd3;
      end else if (ecall_in) begin
         exc_cause = 4'd11;
      end else if (misaligned_store_in) begin
         exc_cause = 4'd6;
      end
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_q  <= ST_RESET;
         cause_q  <= 4'd0;
         i_or_e_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cause_q  <= cause_d;
         i_or_e_q <= i_or_e_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      cause_d         = cause_q;
      i_or_e_d        = i_or_e_q;
      trap_taken_out  = 1'b0;
      pc_src_out      = PC_BOOT;
      flush_out       = 1'b0;
      set_cause_out   = 1'b0;
      set_epc_out     = 1'b0;
      instret_inc_out = 1'b0;
      mie_clear_out   = 1'b0;
      mie_set_out     = 1'b0;
      case (state_q)
         ST_RESET: begin
            pc_src_out = PC_BOOT;
            flush_out  = 1'b1;
            state_d    = ST_OPERATING;
         end
         ST_OPERATING: begin
            pc_src_out      = PC_NEXT;
            instret_inc_out = ~(irq | exc | mret_in);
            if (irq | exc) begin
               state_d  = ST_TRAP_TAKEN;
               cause_d  = irq ? irq_cause : exc_cause;
               i_or_e_d = irq;
            end else if (mret_in) begin
               state_d = ST_TRAP_RETURN;
            end
         end
         ST_TRAP_TAKEN: begin
            trap_taken_out = 1'b1;
            set_cause_out  = 1'b1;
            set_epc_out    = 1'b1;
            mie_clear_out  = 1'b1;
            pc_src_out     = PC_TRAP;
            flush_out      = 1'b1;
            state_d        = ST_OPERATING;
         end
         ST_TRAP_RETURN: begin
            mie_set_out = 1'b1;
            pc_src_out  = PC_EPC;
            flush_out   = 1'b1;
            state_d     = ST_OPERATING;
         end
      endcase
   end

   assign cause_out  = cause_q;
   assign i_or_e_out = i_or_e_q;

endmodule

// File: tb/tb_msrv32_trap_ctrl.sv
// tb/tb_msrv32_trap_ctrl.sv - self-checking bench for msrv32_trap_ctrl
// Directed scenarios plus randomized traffic against a priority-table reference model.
module tb_msrv32_trap_ctrl;

   logic       clk_in = 1'b0;
   logic       reset_in = 1'b1;
   logic       illegal_instr_in = 1'b0, misaligned_load_in = 1'b0, misaligned_store_in = 1'b0;
   logic       misaligned_instr_in = 1'b0, ecall_in = 1'b0, ebreak_in = 1'b0, mret_in = 1'b0;
   logic       mie_in = 1'b0, meie_in = 1'b0, mtie_in = 1'b0, msie_in = 1'b0;
   logic       meip_in = 1'b0, mtip_in = 1'b0, msip_in = 1'b0;
   logic       trap_taken_out, flush_out, set_cause_out, i_or_e_out, set_epc_out;
   logic       instret_inc_out, mie_clear_out, mie_set_out;
   logic [1:0] pc_src_out;
   logic [3:0] cause_out;
   logic [13:0] obs;

   int checks = 0;
   int errors = 0;

   // Stimulus vector bit positions.
   localparam logic [13:0] F_ILL   = 14'h0001;
   localparam logic [13:0] F_LOAD  = 14'h0002;
   localparam logic [13:0] F_STORE = 14'h0004;
   localparam logic [13:0] F_INSTR = 14'h0008;
   localparam logic [13:0] F_ECALL = 14'h0010;
   localparam logic [13:0] F_EBRK  = 14'h0020;
   localparam logic [13:0] F_MRET  = 14'h0040;
   localparam logic [13:0] F_MIE   = 14'h0080;
   localparam logic [13:0] F_MEIE  = 14'h0100;
   localparam logic [13:0] F_MSIE  = 14'h0400;
   localparam logic [13:0] F_MEIP  = 14'h0800;
   localparam logic [13:0] F_MSIP  = 14'h2000;

   localparam int         IRQ_EN   [3] = '{8, 10, 9};
   localparam int         IRQ_PEND [3] = '{11, 13, 12};
   localparam logic [3:0] IRQ_CODE [3] = '{4'd11, 4'd3, 4'd7};
   localparam int         EXC_BIT  [6] = '{3, 0, 5, 4, 2, 1};
   localparam logic [3:0] EXC_CODE [6] = '{4'd0, 4'd2, 4'd3, 4'd11, 4'd6, 4'd4};

   msrv32_trap_ctrl dut (
      .clk_in(clk_in), .reset_in(reset_in),
      .illegal_instr_in(illegal_instr_in), .misaligned_load_in(misaligned_load_in),
      .misaligned_store_in(misaligned_store_in), .misaligned_instr_in(misaligned_instr_in),
      .ecall_in(ecall_in), .ebreak_in(ebreak_in), .mret_in(mret_in), .mie_in(mie_in),
      .meie_in(meie_in), .mtie_in(mtie_in), .msie_in(msie_in),
      .meip_in(meip_in), .mtip_in(mtip_in), .msip_in(msip_in),
      .trap_taken_out(trap_taken_out), .pc_src_out(pc_src_out), .flush_out(flush_out),
      .set_cause_out(set_cause_out), .cause_out(cause_out), .i_or_e_out(i_or_e_out),
      .set_epc_out(set_epc_out), .instret_inc_out(instret_inc_out),
      .mie_clear_out(mie_clear_out), .mie_set_out(mie_set_out)
   );

   always #5 clk_in = ~clk_in;

   assign obs = {trap_taken_out, pc_src_out, flush_out, set_cause_out, cause_out,
                 i_or_e_out, set_epc_out, instret_inc_out, mie_clear_out, mie_set_out};

   function automatic logic [13:0] ev_reset();
      return {1'b0, 2'b00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   endfunction

   function automatic logic [13:0] ev_oper(input logic [3:0] c, input bit ie, input bit ir);
      return {1'b0, 2'b11, 1'b0, 1'b0, c, ie, 1'b0, ir, 1'b0, 1'b0};
   endfunction

   function automatic logic [13:0] ev_trap(input logic [3:0] c, input bit ie);
      return {1'b1, 2'b10, 1'b1, 1'b1, c, ie, 1'b1, 1'b0, 1'b1, 1'b0};
   endfunction

   function automatic logic [13:0] ev_ret(input logic [3:0] c, input bit ie);
      return {1'b0, 2'b01, 1'b1, 1'b0, c, ie, 1'b0, 1'b0, 1'b0, 1'b1};
   endfunction

   // Walks the interrupt table, then the exception table, first hit wins.
   function automatic void ref_decide(input logic [13:0] v, output bit trap, output bit ret,
                                      output logic [3:0] cause, output bit ie);
      trap = 1'b0;
      ret = 1'b0;
      cause = 4'd0;
      ie = 1'b0;
      if (v[7]) begin
         for (int k = 0; k < 3; k++) begin
            if (!trap && v[IRQ_EN[k]] && v[IRQ_PEND[k]]) begin
               trap = 1'b1;
               ie = 1'b1;
               cause = IRQ_CODE[k];
            end
         end
      end
      for (int k = 0; k < 6; k++) begin
         if (!trap && v[EXC_BIT[k]]) begin
            trap = 1'b1;
            cause = EXC_CODE[k];
         end
      end
      ret = !trap && v[6];
   endfunction

   task automatic drive(input logic [13:0] v);
      illegal_instr_in    = v[0];
      misaligned_load_in  = v[1];
      misaligned_store_in = v[2];
      misaligned_instr_in = v[3];
      ecall_in            = v[4];
      ebreak_in           = v[5];
      mret_in             = v[6];
      mie_in              = v[7];
      meie_in             = v[8];
      mtie_in             = v[9];
      msie_in             = v[10];
      meip_in             = v[11];
      mtip_in             = v[12];
      msip_in             = v[13];
   endtask

   task automatic test_reset();
      drive(14'd0);
      repeat (2) @(negedge clk_in);
      #1;
      checks++;
      if (obs !== ev_reset()) begin errors++; $display("FAIL reset_hold got %h want %h", obs, ev_reset()); end
      @(negedge clk_in) reset_in = 1'b0;
      #1;
      checks++;
      if (obs !== ev_reset()) begin errors++; $display("FAIL reset_release got %h want %h", obs, ev_reset()); end
      @(negedge clk_in);
      #1;
      checks++;
      if (obs !== ev_oper(4'd0, 1'b0, 1'b1)) begin errors++; $display("FAIL reset_to_oper got %h want %h", obs, ev_oper(4'd0, 1'b0, 1'b1)); end
      @(posedge clk_in);
      #2 reset_in = 1'b1;
      #1;
      checks++;
      if (obs !== ev_reset()) begin errors++; $display("FAIL reset_async got %h want %h", obs, ev_reset()); end
      @(negedge clk_in) reset_in = 1'b0;
      @(negedge clk_in);
      #1;
      checks++;
      if (obs !== ev_oper(4'd0, 1'b0, 1'b1)) begin errors++; $display("FAIL reset_again got %h want %h", obs, ev_oper(4'd0, 1'b0, 1'b1)); end
   endtask

   task automatic test_illegal();
      @(negedge clk_in) drive(F_ILL);
      #1;
      checks++;
      if (obs !== ev_oper(4'd0, 1'b0, 1'b0)) begin errors++; $display("FAIL illegal_detect got %h want %h", obs, ev_oper(4'd0, 1'b0, 1'b0)); end
      @(negedge clk_in) drive(14'd0);
      #1;
      checks++;
      if (obs !== ev_trap(4'd2, 1'b0)) begin errors++; $display("FAIL illegal_trap got %h want %h", obs, ev_trap(4'd2, 1'b0)); end
      @(negedge clk_in);
      #1;
      checks++;
      if (obs !== ev_oper(4'd2, 1'b0, 1'b1)) begin errors++; $display("FAIL illegal_resume got %h want %h", obs, ev_oper(4'd2, 1'b0, 1'b1)); end
   endtask

   task automatic test_priority();
      logic [13:0] v;
      v = F_MEIP | F_MEIE | F_MIE | F_ECALL | F_MSIP | F_MSIE;
      @(negedge clk_in) drive(v);
      #1;
      checks++;
      if (obs !== ev_oper(4'd2, 1'b0, 1'b0)) begin errors++; $display("FAIL prio_detect got %h want %h", obs, ev_oper(4'd2, 1'b0, 1'b0)); end
      @(negedge clk_in) drive(14'd0);
      #1;
      checks++;
      if (obs !== ev_trap(4'd11, 1'b1)) begin errors++; $display("FAIL prio_irq got %h want %h", obs, ev_trap(4'd11, 1'b1)); end
      @(negedge clk_in) drive(v & ~F_MIE);
      #1;
      checks++;
      if (obs !== ev_oper(4'd11, 1'b1, 1'b0)) begin errors++; $display("FAIL prio_nomie_detect got %h want %h", obs, ev_oper(4'd11, 1'b1, 1'b0)); end
      @(negedge clk_in) drive(14'd0);
      #1;
      checks++;
      if (obs !== ev_trap(4'd11, 1'b0)) begin errors++; $display("FAIL prio_ecall got %h want %h", obs, ev_trap(4'd11, 1'b0)); end
   endtask

   task automatic test_exc_order();
      @(negedge clk_in) drive(F_LOAD | F_STORE);
      #1;
      checks++;
      if (obs !== ev_oper(4'd11, 1'b0, 1'b0)) begin errors++; $display("FAIL order_ls_detect got %h want %h", obs, ev_oper(4'd11, 1'b0, 1'b0)); end
      @(negedge clk_in) drive(14'd0);
      #1;
      checks++;
      if (obs !== ev_trap(4'd6, 1'b0)) begin errors++; $display("FAIL order_store got %h want %h", obs, ev_trap(4'd6, 1'b0)); end
      @(negedge clk_in) drive(F_INSTR | F_ILL);
      #1;
      @(negedge clk_in) drive(14'd0);
      #1;
      checks++;
      if (obs !== ev_trap(4'd0, 1'b0)) begin errors++; $display("FAIL order_instr got %h want %h", obs, ev_trap(4'd0, 1'b0)); end
   endtask

   task automatic test_mret();
      @(negedge clk_in) drive(F_MRET);
      #1;
      checks++;
      if (obs !== ev_oper(4'd0, 1'b0, 1'b0)) begin errors++; $display("FAIL mret_detect got %h want %h", obs, ev_oper(4'd0, 1'b0, 1'b0)); end
      @(negedge clk_in) drive(F_ILL);
      #1;
      checks++;
      if (obs !== ev_ret(4'd0, 1'b0)) begin errors++; $display("FAIL mret_return got %h want %h", obs, ev_ret(4'd0, 1'b0)); end
      @(negedge clk_in) drive(F_MRET | F_EBRK);
      #1;
      checks++;
      if (obs !== ev_oper(4'd0, 1'b0, 1'b0)) begin errors++; $display("FAIL mret_ignored_in_return got %h want %h", obs, ev_oper(4'd0, 1'b0, 1'b0)); end
      @(negedge clk_in) drive(14'd0);
      #1;
      checks++;
      if (obs !== ev_trap(4'd3, 1'b0)) begin errors++; $display("FAIL mret_ebreak got %h want %h", obs, ev_trap(4'd3, 1'b0)); end
   endtask

   task automatic test_reset_mid_trap();
      @(negedge clk_in) drive(F_ILL);
      @(negedge clk_in) drive(14'd0);
      #1;
      checks++;
      if (obs !== ev_trap(4'd2, 1'b0)) begin errors++; $display("FAIL midtrap_enter got %h want %h", obs, ev_trap(4'd2, 1'b0)); end
      #2 reset_in = 1'b1;
      #1;
      checks++;
      if (obs !== ev_reset()) begin errors++; $display("FAIL midtrap_strobes got %h want %h", obs, ev_reset()); end
      @(negedge clk_in) reset_in = 1'b0;
      @(negedge clk_in);
      #1;
      checks++;
      if (obs !== ev_oper(4'd0, 1'b0, 1'b1)) begin errors++; $display("FAIL midtrap_cause_cleared got %h want %h", obs, ev_oper(4'd0, 1'b0, 1'b1)); end
   endtask

   task automatic test_random();
      int          phase;
      logic [3:0]  m_cause, n_cause;
      bit          m_ie, n_ie, trap, ret;
      logic [13:0] v, e;
      phase = 0;
      m_cause = 4'd0;
      m_ie = 1'b0;
      for (int n = 0; n < 500; n++) begin
         for (int b = 0; b < 7; b++) v[b] = ($urandom_range(0, 7) == 0);
         for (int b = 7; b < 14; b++) v[b] = $urandom_range(0, 1) == 1;
         @(negedge clk_in) drive(v);
         #1;
         ref_decide(v, trap, ret, n_cause, n_ie);
         if (phase == 1) e = ev_trap(m_cause, m_ie);
         else if (phase == 2) e = ev_ret(m_cause, m_ie);
         else e = ev_oper(m_cause, m_ie, !(trap || ret));
         checks++;
         if (obs !== e) begin errors++; $display("FAIL random_%0d got %h want %h in %h", n, obs, e, v); end
         if (phase != 0) phase = 0;
         else if (trap) begin
            phase = 1;
            m_cause = n_cause;
            m_ie = n_ie;
         end else if (ret) phase = 2;
      end
      drive(14'd0);
   endtask

   initial begin
      test_reset();
      test_illegal();
      test_priority();
      test_exc_order();
      test_mret();
      test_reset_mid_trap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/msrv32_trap_ctrl.md
Name: msrv32_trap_ctrl

Overview:
Machine-mode trap controller for the msrv32 core. It consumes the exception flags the decoder produces, plus interrupt pending/enable bits from the CSR file. It returns trap_taken to the decoder, which gates the decoder's misaligned flags. It also drives PC source selection, pipeline flush, mcause/mepc capture, mstatus.MIE save/restore and instret increment.

Parameters:
none.

Ports:
clk_in  input  1  core clock, rising edge
reset_in  input  1  asynchronous reset, active-high
illegal_instr_in  input  1  decoder: illegal instruction
misaligned_load_in  input  1  decoder: misaligned load (already gated by trap_taken)
misaligned_store_in  input  1  decoder: misaligned store
misaligned_instr_in  input  1  target PC bit1 set on taken jump/branch
ecall_in  input  1  ECALL decoded
ebreak_in  input  1  EBREAK decoded
mret_in  input  1  MRET decoded
mie_in  input  1  mstatus.MIE
meie_in / mtie_in / msie_in  input  1 each  mie enable bits
meip_in / mtip_in / msip_in  input  1 each  mip pending bits
trap_taken_out  output  1  to decoder trap_taken_in and CSR file
pc_src_out  output  2  00 boot, 01 mepc, 10 trap vector, 11 next PC
flush_out  output  1  kill the instruction in the second stage
set_cause_out  output  1  write mcause
cause_out  output  4  mcause code
i_or_e_out  output  1  mcause[31]: 1 = interrupt
set_epc_out  output  1  write mepc
instret_inc_out  output  1  instruction retired
mie_clear_out  output  1  MPIE<=MIE, MIE<=0
mie_set_out  output  1  MIE<=MPIE

Behaviour:
- FSM states:
  - RESET=2'b00
  - OPERATING=2'b01
  - TRAP_TAKEN=2'b10
  - TRAP_RETURN=2'b11
- Async reset drives the FSM to RESET.
- Outputs in RESET: pc_src=00, flush=1; all other outputs 0.
- State registers reset to: cause reg 0, i_or_e reg 0.
- RESET -> OPERATING unconditionally on the next edge.
- Exception detection (OPERATING only): exc = illegal | misaligned_load | misaligned_store | misaligned_instr | ecall | ebreak.
- Interrupt detection (OPERATING only): irq = mie_in & ((meie&meip) | (msie&msip) | (mtie&mtip)).
- OPERATING transitions:
  - irq|exc -> TRAP_TAKEN.
  - else mret_in -> TRAP_RETURN.
  - else stay.
- Cause priority: interrupts over exceptions.
  - Interrupt order: MEI (11) > MSI (3) > MTI (7); i_or_e=1.
  - Exception order: misaligned_instr (0) > illegal (2) > ebreak (3) > ecall (11) > misaligned_store (6) > misaligned_load (4); i_or_e=0.
- Cause and i_or_e registers are loaded on the edge that enters TRAP_TAKEN and held otherwise. cause_out and i_or_e_out are driven from these registers.
- OPERATING outputs: pc_src=11, flush=0, instret_inc = ~(irq|exc|mret_in); others 0.
- TRAP_TAKEN (one cycle) outputs: trap_taken=1, set_cause=1, set_epc=1, mie_clear=1, pc_src=10, flush=1, instret_inc=0. Then -> OPERATING.
- TRAP_RETURN (one cycle) outputs: mie_set=1, pc_src=01, flush=1, instret_inc=0. Then -> OPERATING.
- Trap latency: one cycle from detection to trap_taken_out.
- Inputs arriving in TRAP_TAKEN or TRAP_RETURN are ignored; the flushed instruction is discarded.
- Simultaneous mret and exception: exception wins; mret is not taken.
- With mie_in=0, pending interrupts are ignored; exceptions are still taken.
- Reset asserted in TRAP_TAKEN or TRAP_RETURN: immediately returns to RESET outputs. mepc/mcause write strobes drop in the same cycle.
- All outputs are Moore (state and registers only), except instret_inc_out, which is combinational in OPERATING.

Test Plan:
- Reset: assert reset_in mid-cycle -> pc_src=00, flush=1, trap_taken=0. Release -> next cycle pc_src=11, instret_inc=1.
- Illegal instruction: illegal_instr_in=1 for one cycle in OPERATING -> that cycle instret_inc=0. Next cycle trap_taken=1, cause=2, i_or_e=0, set_epc=1, mie_clear=1, pc_src=10, flush=1. Then OPERATING.
- Priority: meip=meie=mie=1 together with ecall_in=1 and msip=msie=1 -> cause=11, i_or_e=1. Repeat with mie_in=0 -> cause=11, i_or_e=0 (ecall).
- Exception order: misaligned_load_in=1 with misaligned_store_in=1 -> cause=6. misaligned_instr_in=1 with illegal_instr_in=1 -> cause=0.
- MRET: mret_in=1 alone -> next cycle mie_set=1, pc_src=01, flush=1, trap_taken=0. mret_in=1 with ebreak_in=1 -> TRAP_TAKEN, cause=3.
- Reset mid-trap: assert reset_in while in TRAP_TAKEN -> set_cause and set_epc drop to 0 without waiting for a clock edge. After release, cause_out=0.
